// File: rtl/qix_sound_cmd_mailbox.sv
// rtl/qix_sound_cmd_mailbox.sv - sound command FIFO with IRQ presentation, ack wait and IRQ-low holdoff
module qix_sound_cmd_mailbox #(
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 8
) (
   input  logic                       clk_20m,
   input  logic                       reset,
   input  logic                       cpu_ce,
   input  logic                       pause,
   input  logic                       flush,
   input  logic [7:0]                 cmd_data,
   input  logic                       cmd_strobe,
   output logic [7:0]                 snd_cmd,
   output logic                       snd_irq,
   input  logic                       snd_ack,
   output logic                       cmd_busy,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int HO_W  = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_HOLDOFF  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         snd_cmd_q, snd_cmd_d;
   logic               snd_irq_q, snd_irq_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic [HO_W-1:0]    hold_q, hold_d;
   logic [7:0]         mem_q [DEPTH];
   logic               push, pop, full, ovf_set;

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      snd_cmd_d = snd_cmd_q;
      snd_irq_d = snd_irq_q;
      hold_d    = hold_q;
      push      = 1'b0;
      pop       = 1'b0;
      full      = (count_q == CNT_W'(DEPTH));

      if (flush) begin
         state_d   = S_IDLE;
         snd_irq_d = 1'b0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         hold_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (count_q != '0 && !pause) begin
                  pop       = 1'b1;
                  snd_cmd_d = mem_q[rd_ptr_q];
                  snd_irq_d = 1'b1;
                  state_d   = S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (snd_ack) begin
                  snd_irq_d = 1'b0;
                  hold_d    = HO_W'(HOLDOFF);
                  state_d   = S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               // pause freezes the gap so a paused sound CPU still sees the full IRQ-low time
               if (cpu_ce && !pause) begin
                  if (hold_q == HO_W'(1)) begin
                     hold_d  = '0;
                     state_d = S_IDLE;
                  end else begin
                     hold_d = hold_q - 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase

         push = cmd_strobe && (!full || pop);
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end

      ovf_set = cmd_strobe && !flush && full && !pop;
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;

      // computed from next state so the registered bit always matches the current state and count
      busy_d = (count_d != '0) || (state_d != S_IDLE);
   end

   always_ff @(posedge clk_20m) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         snd_cmd_q <= 8'h00;
         snd_irq_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         snd_cmd_q <= snd_cmd_d;
         snd_irq_q <= snd_irq_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         hold_q    <= hold_d;
      end
   end

   always_ff @(posedge clk_20m) begin
      if (push) mem_q[wr_ptr_q] <= cmd_data;
   end

   assign snd_cmd    = snd_cmd_q;
   assign snd_irq    = snd_irq_q;
   assign cmd_busy   = busy_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_qix_sound_cmd_mailbox.sv
// tb/tb_qix_sound_cmd_mailbox.sv - self-checking bench for qix_sound_cmd_mailbox
module tb_qix_sound_cmd_mailbox;

   localparam int DEPTH   = 4;
   localparam int HOLDOFF = 8;

   logic       clk_20m = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_ce = 1'b0;
   logic       pause = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_strobe = 1'b0;
   logic [7:0] snd_cmd;
   logic       snd_irq;
   logic       snd_ack = 1'b0;
   logic       cmd_busy;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       ovf_clr = 1'b0;

   int total = 0;
   int bad = 0;

   logic [7:0] m_q [$];
   logic [7:0] m_cmd = 8'h00;
   bit         m_present = 0;
   int         m_hold = 0;
   bit         m_ovf = 0;

   qix_sound_cmd_mailbox #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
      .clk_20m    (clk_20m),
      .reset      (reset),
      .cpu_ce     (cpu_ce),
      .pause      (pause),
      .flush      (flush),
      .cmd_data   (cmd_data),
      .cmd_strobe (cmd_strobe),
      .snd_cmd    (snd_cmd),
      .snd_irq    (snd_irq),
      .snd_ack    (snd_ack),
      .cmd_busy   (cmd_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk_20m = ~clk_20m;

   // Reference: a byte queue plus "presenting" flag and remaining holdoff pulses.
   task automatic model_step();
      bit ovf_set;
      ovf_set = 0;
      if (!reset) begin
         m_q.delete();
         m_cmd = 8'h00; m_present = 0; m_hold = 0; m_ovf = 0;
      end else begin
         if (flush) begin
            m_q.delete();
            m_present = 0; m_hold = 0;
         end else begin
            if (m_present) begin
               if (snd_ack) begin m_present = 0; m_hold = HOLDOFF; end
            end else if (m_hold > 0) begin
               if (cpu_ce && !pause) m_hold = m_hold - 1;
            end else if (m_q.size() > 0 && !pause) begin
               m_cmd = m_q.pop_front();
               m_present = 1;
            end
            if (cmd_strobe) begin
               if (m_q.size() < DEPTH) m_q.push_back(cmd_data);
               else ovf_set = 1;
            end
         end
         if (ovf_set) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_20m);
      #1;
      cmd_strobe = 0; snd_ack = 0; flush = 0; ovf_clr = 0; cpu_ce = 0;
   endtask

   task automatic finish_ack();
      snd_ack = 1;
      tick();
      for (int i = 0; i < HOLDOFF; i++) begin cpu_ce = 1; tick(); end
   endtask

   task automatic test_reset();
      reset = 0; tick(); reset = 1;
      total++; if (snd_cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd: got %h want 00", snd_cmd); end
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", snd_irq); end
      total++; if (cmd_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cmd_busy); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_single();
      cmd_data = 8'h5A; cmd_strobe = 1; tick();
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count_n1: got %0d want 1", fifo_count); end
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL single_irq_n1: got %b want 0", snd_irq); end
      tick();
      total++; if (snd_irq !== 1'b1) begin bad++; $display("FAIL single_irq_n2: got %b want 1", snd_irq); end
      total++; if (snd_cmd !== 8'h5A) begin bad++; $display("FAIL single_cmd: got %h want 5a", snd_cmd); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count_n2: got %0d want 0", fifo_count); end
      total++; if (cmd_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", cmd_busy); end
      tick(); tick();
      snd_ack = 1; tick();
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL single_irq_ack: got %b want 0", snd_irq); end
      for (int i = 0; i < HOLDOFF - 1; i++) begin cpu_ce = 1; tick(); end
      total++; if (cmd_busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold: got %b want 1", cmd_busy); end
      cpu_ce = 1; tick();
      total++; if (cmd_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", cmd_busy); end
      total++; if (snd_cmd !== 8'h5A) begin bad++; $display("FAIL single_cmd_kept: got %h want 5a", snd_cmd); end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 3; k++) begin cmd_data = 8'(k); cmd_strobe = 1; tick(); end
      total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
      for (int k = 0; k < 3; k++) begin
         total++; if (snd_cmd !== 8'(k + 1)) begin bad++; $display("FAIL b2b_cmd: got %h want %h", snd_cmd, 8'(k + 1)); end
         total++; if (snd_irq !== 1'b1) begin bad++; $display("FAIL b2b_irq_hi: got %b want 1", snd_irq); end
         snd_ack = 1; tick();
         for (int i = 0; i < HOLDOFF; i++) begin
            total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL b2b_gap: pulse %0d got %b want 0", i, snd_irq); end
            cpu_ce = 1; tick();
         end
         total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL b2b_gap_end: got %b want 0", snd_irq); end
         tick();
         if (k < 2) begin
            total++; if (snd_irq !== 1'b1) begin bad++; $display("FAIL b2b_next_irq: got %b want 1", snd_irq); end
         end else begin
            total++; if (cmd_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", cmd_busy); end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_order [4];
      exp_order[0] = 8'h12; exp_order[1] = 8'h13; exp_order[2] = 8'h14; exp_order[3] = 8'hA5;
      for (int k = 0; k < DEPTH + 2; k++) begin cmd_data = 8'h10 + 8'(k); cmd_strobe = 1; tick(); end
      total++; if (snd_cmd !== 8'h10) begin bad++; $display("FAIL ovf_presented: got %h want 10", snd_cmd); end
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
      ovf_clr = 1; tick();
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      ovf_clr = 1; cmd_data = 8'h99; cmd_strobe = 1; tick();
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count_kept: got %0d want 4", fifo_count); end
      ovf_clr = 1; tick();
      finish_ack();
      cmd_data = 8'hA5; cmd_strobe = 1; tick();
      total++; if (snd_cmd !== 8'h11) begin bad++; $display("FAIL ovf_pushpop_cmd: got %h want 11", snd_cmd); end
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_pushpop_count: got %0d want 4", fifo_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pushpop_ovf: got %b want 0", overflow); end
      for (int k = 0; k < 4; k++) begin
         finish_ack(); tick();
         total++; if (snd_cmd !== exp_order[k]) begin bad++; $display("FAIL ovf_drain: got %h want %h", snd_cmd, exp_order[k]); end
      end
      finish_ack();
      total++; if (cmd_busy !== 1'b0) begin bad++; $display("FAIL ovf_drained_busy: got %b want 0", cmd_busy); end
   endtask

   task automatic test_pause();
      pause = 1;
      cmd_data = 8'h21; cmd_strobe = 1; tick();
      cmd_data = 8'h22; cmd_strobe = 1; tick();
      tick(); tick();
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL pause_idle_irq: got %b want 0", snd_irq); end
      total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pause_count: got %0d want 2", fifo_count); end
      total++; if (cmd_busy !== 1'b1) begin bad++; $display("FAIL pause_busy: got %b want 1", cmd_busy); end
      pause = 0; tick();
      total++; if (snd_irq !== 1'b1 || snd_cmd !== 8'h21) begin bad++; $display("FAIL pause_release: got irq=%b cmd=%h want 1/21", snd_irq, snd_cmd); end
      pause = 1; snd_ack = 1; tick();
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL pause_ack: got %b want 0", snd_irq); end
      for (int i = 0; i < 10; i++) begin cpu_ce = 1; tick(); end
      total++; if (cmd_busy !== 1'b1) begin bad++; $display("FAIL pause_frozen_busy: got %b want 1", cmd_busy); end
      pause = 0;
      for (int i = 0; i < HOLDOFF - 1; i++) begin cpu_ce = 1; tick(); end
      tick();
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL pause_frozen_gap: got %b want 0", snd_irq); end
      cpu_ce = 1; tick(); tick();
      total++; if (snd_irq !== 1'b1 || snd_cmd !== 8'h22) begin bad++; $display("FAIL pause_second: got irq=%b cmd=%h want 1/22", snd_irq, snd_cmd); end
      finish_ack(); tick();
   endtask

   task automatic test_flush();
      for (int k = 0; k < 4; k++) begin cmd_data = 8'h31 + 8'(k); cmd_strobe = 1; tick(); end
      total++; if (fifo_count !== 3'd3 || snd_irq !== 1'b1) begin bad++; $display("FAIL flush_setup: got count=%0d irq=%b want 3/1", fifo_count, snd_irq); end
      flush = 1; cmd_data = 8'h77; cmd_strobe = 1; snd_ack = 1; tick();
      total++; if (snd_irq !== 1'b0) begin bad++; $display("FAIL flush_irq: got %b want 0", snd_irq); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", fifo_count); end
      total++; if (cmd_busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", cmd_busy); end
      total++; if (snd_cmd !== 8'h31) begin bad++; $display("FAIL flush_cmd_kept: got %h want 31", snd_cmd); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b want 0", overflow); end
      snd_ack = 1; tick(); tick(); tick();
      total++; if (snd_irq !== 1'b0 || cmd_busy !== 1'b0) begin bad++; $display("FAIL flush_stray_ack: got irq=%b busy=%b want 0/0", snd_irq, cmd_busy); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin cmd_data = 8'h41 + 8'(k); cmd_strobe = 1; tick(); end
      snd_ack = 1; tick();
      for (int i = 0; i < 3; i++) begin cpu_ce = 1; tick(); end
      total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rmid_setup: got %0d want 2", fifo_count); end
      reset = 0; tick(); reset = 1;
      total++; if (snd_cmd !== 8'h00 || snd_irq !== 1'b0) begin bad++; $display("FAIL rmid_out: got cmd=%h irq=%b want 00/0", snd_cmd, snd_irq); end
      total++; if (fifo_count !== 3'd0 || cmd_busy !== 1'b0) begin bad++; $display("FAIL rmid_state: got count=%0d busy=%b want 0/0", fifo_count, cmd_busy); end
      for (int i = 0; i < 20; i++) begin cpu_ce = 1; tick(); end
      total++; if (snd_irq !== 1'b0 || cmd_busy !== 1'b0) begin bad++; $display("FAIL rmid_quiet: got irq=%b busy=%b want 0/0", snd_irq, cmd_busy); end
      cmd_data = 8'h55; cmd_strobe = 1; tick(); tick();
      total++; if (snd_irq !== 1'b1 || snd_cmd !== 8'h55) begin bad++; $display("FAIL rmid_new: got irq=%b cmd=%h want 1/55", snd_irq, snd_cmd); end
      finish_ack();
   endtask

   task automatic test_random();
      reset = 0; pause = 0; tick(); reset = 1;
      for (int c = 0; c < 4000; c++) begin
         cmd_strobe = ($urandom_range(0, 99) < 30);
         cmd_data   = 8'($urandom);
         snd_ack    = ($urandom_range(0, 99) < 15);
         cpu_ce     = ($urandom_range(0, 99) < 50);
         flush      = ($urandom_range(0, 99) < 2);
         ovf_clr    = ($urandom_range(0, 99) < 3);
         reset      = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 99) < 5) pause = ~pause;
         tick();
         total++;
         if (snd_cmd !== m_cmd || snd_irq !== m_present || fifo_count !== 3'(m_q.size()) ||
             overflow !== m_ovf || cmd_busy !== (m_q.size() != 0 || m_present || m_hold > 0)) begin
            bad++;
            if (bad < 20)
               $display("FAIL random cyc=%0d: got cmd=%h irq=%b cnt=%0d ovf=%b busy=%b want cmd=%h irq=%b cnt=%0d ovf=%b busy=%b",
                        c, snd_cmd, snd_irq, fifo_count, overflow, cmd_busy, m_cmd, m_present, m_q.size(), m_ovf,
                        (m_q.size() != 0 || m_present || m_hold > 0));
         end
      end
      reset = 1; pause = 0;
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_pause();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
